// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared constants and helpers for the programmable sequence
// detector.
//   - PAT_W_DEF / LEN_W_DEF : default pattern width and the matching width of
//                             the pattern-length field ($clog2(PAT_W+1))
//   - SEG7_*                : active-low 7-segment codes {g..a}
//   - bcd_to_seg7()         : BCD digit to segment code, non-BCD blanks
package seq_det_pkg;

    localparam int PAT_W_DEF = 8;
    localparam int LEN_W_DEF = $clog2(PAT_W_DEF + 1);

    localparam logic [6:0] SEG7_0     = 7'h40;
    localparam logic [6:0] SEG7_1     = 7'h79;
    localparam logic [6:0] SEG7_2     = 7'h24;
    localparam logic [6:0] SEG7_3     = 7'h30;
    localparam logic [6:0] SEG7_4     = 7'h19;
    localparam logic [6:0] SEG7_5     = 7'h12;
    localparam logic [6:0] SEG7_6     = 7'h02;
    localparam logic [6:0] SEG7_7     = 7'h78;
    localparam logic [6:0] SEG7_8     = 7'h00;
    localparam logic [6:0] SEG7_9     = 7'h18;
    localparam logic [6:0] SEG7_BLANK = 7'h7F;

    function automatic logic [6:0] bcd_to_seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG7_0;
            4'd1:    s = SEG7_1;
            4'd2:    s = SEG7_2;
            4'd3:    s = SEG7_3;
            4'd4:    s = SEG7_4;
            4'd5:    s = SEG7_5;
            4'd6:    s = SEG7_6;
            4'd7:    s = SEG7_7;
            4'd8:    s = SEG7_8;
            4'd9:    s = SEG7_9;
            default: s = SEG7_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seq_bcd_counter.sv
// seq_bcd_counter: DIGITS-digit BCD hit counter with sticky overflow and
// active-low 7-segment decode of the registered count.
//   clk, rst  : clock, synchronous active-high reset
//   inc       : count one hit this cycle
//   clr       : clear count and overflow (wins over inc)
//   count     : BCD count, digit 0 at [3:0]
//   seg       : segment codes, digit 0 at [6:0]
//   overflow  : set by a hit while the count is all-9s
// Macro SEQ_DET_SATURATE_EN: defined -> all-9s holds on overflow;
// undefined -> count wraps to all-0s.
module seq_bcd_counter
    import seq_det_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc,
    input  logic                  clr,
    output logic [4*DIGITS-1:0]   count,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  overflow
);

    logic [DIGITS-1:0][3:0] cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic                   all_nines;
    logic                   carry;

    always_comb begin
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        all_nines = 1'b1;
        carry     = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (cnt_q[d] != 4'd9) all_nines = 1'b0;
        end
        if (clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (inc) begin
            if (all_nines) begin
                ovf_d = 1'b1;
`ifdef SEQ_DET_SATURATE_EN
                cnt_d = cnt_q;
`else
                cnt_d = '0;
`endif
            end else begin
                // Ripple the increment up through the digits.
                carry = 1'b1;
                for (int d = 0; d < DIGITS; d++) begin
                    if (carry) begin
                        if (cnt_q[d] == 4'd9) begin
                            cnt_d[d] = 4'd0;
                        end else begin
                            cnt_d[d] = cnt_q[d] + 4'd1;
                            carry    = 1'b0;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign count    = cnt_q;
    assign overflow = ovf_q;

    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
        assign seg[7*g +: 7] = bcd_to_seg7(cnt_q[g]);
    end

endmodule

// File: rtl/seq_detector_prog.sv
// seq_detector_prog: programmable serial-pattern detector with BCD hit
// counter and 7-segment outputs.
//   clk, rst     : clock, synchronous active-high reset
//   ena          : advance enable; low holds all state and forces z=0
//   sig_in       : serial bit under test
//   overlap      : 1 keeps history after a match, 0 flushes it
//   pat_load     : latch pat_value / pat_len (clamped to PAT_W)
//   pat_value    : pattern, bit [len-1] is received first
//   pat_len      : pattern length, 0 disables detection
//   cnt_clr      : clear hit count and overflow
//   z            : combinational match strobe on the completing bit
//   count, seg   : BCD hit count and its active-low segment decode
//   overflow     : sticky counter overflow
// Macro SEQ_DET_SATURATE_EN selects saturating vs wrapping count.
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = PAT_W_DEF,
    parameter int               DIGITS  = 2,
    parameter logic [PAT_W-1:0] RST_PAT = 8'b0000_1001,
    parameter int               RST_LEN = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ena,
    input  logic                       sig_in,
    input  logic                       overlap,
    input  logic                       pat_load,
    input  logic [PAT_W-1:0]           pat_value,
    input  logic [$clog2(PAT_W+1)-1:0] pat_len,
    input  logic                       cnt_clr,
    output logic                       z,
    output logic [4*DIGITS-1:0]        count,
    output logic [7*DIGITS-1:0]        seg,
    output logic                       overflow
);

    localparam int               LEN_W   = $clog2(PAT_W + 1);
    localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);
    localparam logic [PAT_W:0]   ONE_EXT = {{PAT_W{1'b0}}, 1'b1};

    logic [PAT_W-1:0] hist_q, hist_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] fill_q, fill_d;

    logic [PAT_W-1:0] window;
    logic [PAT_W:0]   mask_ext;
    logic [PAT_W-1:0] mask;
    logic [LEN_W:0]   fill_p1;
    logic             fill_ok;
    logic             bits_ok;
    logic             match;

    // Match logic: the newest bit joins the history to form the window; only
    // the low len bits take part, selected by a one-hot-minus-one mask.
    always_comb begin
        window   = {hist_q[PAT_W-2:0], sig_in};
        mask_ext = (ONE_EXT << len_q) - ONE_EXT;
        mask     = mask_ext[PAT_W-1:0];
        fill_p1  = {1'b0, fill_q} + {{LEN_W{1'b0}}, 1'b1};
        fill_ok  = fill_p1 >= {1'b0, len_q};
        bits_ok  = ((window ^ pat_q) & mask) == '0;
        match    = ena & ~rst & ~pat_load & (len_q != '0) & fill_ok & bits_ok;
    end

    assign z = match;

    always_comb begin
        hist_d = hist_q;
        pat_d  = pat_q;
        len_d  = len_q;
        fill_d = fill_q;
        if (ena) begin
            hist_d = window;
            if (match && !overlap) begin
                fill_d = '0;
            end else if (fill_q != PAT_W_L) begin
                fill_d = fill_q + {{(LEN_W-1){1'b0}}, 1'b1};
            end
        end
        // A load restarts the fill so a new match needs len bits seen
        // after the load; the history itself keeps shifting.
        if (pat_load) begin
            pat_d  = pat_value;
            len_d  = (pat_len > PAT_W_L) ? PAT_W_L : pat_len;
            fill_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            pat_q  <= RST_PAT;
            len_q  <= LEN_W'(RST_LEN);
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            pat_q  <= pat_d;
            len_q  <= len_d;
            fill_q <= fill_d;
        end
    end

    // A disabled cycle must not change the count, so the clear is gated too.
    seq_bcd_counter #(
        .DIGITS (DIGITS)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .inc      (match),
        .clr      (cnt_clr & ena),
        .count    (count),
        .seg      (seg),
        .overflow (overflow)
    );

endmodule

// File: tb/tb_seq_detector_prog.sv
module tb_seq_detector_prog;

    localparam int PAT_W  = 8;
    localparam int DIGITS = 2;
    localparam int LEN_W  = 4;
    localparam int MAXC   = 99;

    logic                  clk = 1'b0;
    logic                  rst, ena, sig_in, overlap, pat_load, cnt_clr;
    logic [PAT_W-1:0]      pat_value;
    logic [LEN_W-1:0]      pat_len;
    logic                  z, overflow;
    logic [4*DIGITS-1:0]   count;
    logic [7*DIGITS-1:0]   seg;

    seq_detector_prog #(.PAT_W(PAT_W), .DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .ena(ena), .sig_in(sig_in), .overlap(overlap),
        .pat_load(pat_load), .pat_value(pat_value), .pat_len(pat_len),
        .cnt_clr(cnt_clr), .z(z), .count(count), .seg(seg), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                  cyc;
        logic                z;
        logic [4*DIGITS-1:0] cnt;
        logic [7*DIGITS-1:0] seg;
        logic                ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc_no = 0;

    // Reference model: the pattern as an integer, the bits seen since the
    // last flush as a queue, and the hit count as a plain integer.
    logic [31:0] m_pat;
    int          m_len;
    bit          fresh[$];
    int          m_cnt;
    bit          m_ovf;

    logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h18};

    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        int p;
        p = 1;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [7*DIGITS-1:0] to_seg(input int v);
        logic [7*DIGITS-1:0] r;
        int p;
        p = 1;
        for (int d = 0; d < DIGITS; d++) begin
            r[7*d +: 7] = seg_tbl[(v / p) % 10];
            p = p * 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_pat = 32'h9;
        m_len = 4;
        fresh.delete();
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    // One clock of stimulus: drive, predict, push expectation, advance model.
    task automatic cyc(input bit r, input bit e, input bit s, input bit o,
                       input bit l, input logic [PAT_W-1:0] pv,
                       input logic [LEN_W-1:0] pl, input bit c);
        bit   mm;
        exp_t x;
        rst = r; ena = e; sig_in = s; overlap = o;
        pat_load = l; pat_value = pv; pat_len = pl; cnt_clr = c;
        mm = 1'b0;
        if (!r && e && !l && m_len != 0) begin
            bit tmp[$];
            tmp = fresh;
            tmp.push_back(s);
            if (tmp.size() >= m_len) begin
                mm = 1'b1;
                for (int i = 0; i < m_len; i++)
                    if (tmp[tmp.size() - m_len + i] != m_pat[m_len-1-i]) mm = 1'b0;
            end
        end
        x.cyc = cyc_no; x.z = mm; x.cnt = to_bcd(m_cnt);
        x.seg = to_seg(m_cnt); x.ovf = m_ovf;
        exp_q.push_back(x);
        if (r) begin
            model_reset();
        end else begin
            if (e && c) begin
                m_cnt = 0; m_ovf = 1'b0;
            end else if (mm) begin
                if (m_cnt == MAXC) begin
                    m_ovf = 1'b1;
`ifdef SEQ_DET_SATURATE_EN
                    m_cnt = MAXC;
`else
                    m_cnt = 0;
`endif
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
            if (l) begin
                m_pat = 32'(pv);
                m_len = (int'(pl) > PAT_W) ? PAT_W : int'(pl);
                fresh.delete();
            end else if (e) begin
                if (mm && !o) fresh.delete();
                else begin
                    fresh.push_back(s);
                    if (fresh.size() > PAT_W) void'(fresh.pop_front());
                end
            end
        end
        cyc_no++;
        @(posedge clk);
        #1;
    endtask

    task automatic bit_in(input bit s, input bit o);
        cyc(0, 1, s, o, 0, '0, '0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 1'($urandom), 1, 0, '0, '0, 0);
    endtask

    task automatic chk(input string name, input int c, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
        end
    endtask

    // Monitor: every presented cycle is popped and compared mid-cycle.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("z", x.cyc, 32'(z), 32'(x.z));
                chk("count", x.cyc, 32'(count), 32'(x.cnt));
                chk("seg", x.cyc, 32'(seg), 32'(x.seg));
                chk("overflow", x.cyc, 32'(overflow), 32'(x.ovf));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        bit st1[7] = '{1, 0, 0, 1, 0, 0, 1};
        bit st2[6] = '{0, 1, 1, 0, 1, 1};
        logic [PAT_W-1:0] pv;
        rst = 1; ena = 0; sig_in = 0; overlap = 1; pat_load = 0;
        pat_value = '0; pat_len = '0; cnt_clr = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        // Reset state observed while rst is still high.
        cyc(1, 1, 1, 1, 1, 8'hFF, 4'd2, 1);

        // Default pattern 1001, overlapping.
        foreach (st1[i]) bit_in(st1[i], 1);
        idle(2);
        cyc(0, 1, 0, 1, 0, '0, '0, 1);
        // Non-overlapping.
        foreach (st1[i]) bit_in(st1[i], 0);
        idle(2);

        // Mid-stream load of 011 with the window already matching 011.
        bit_in(0, 1); bit_in(1, 1);
        cyc(0, 1, 1, 1, 1, 8'b011, 4'd3, 0);
        foreach (st2[i]) bit_in(st2[i], 1);
        idle(1);

        // Counter range: single-bit pattern, every 1 is a hit.
        cyc(0, 1, 0, 1, 1, 8'h01, 4'd1, 1);
        for (int i = 0; i < 99; i++) bit_in(1, 1);
        idle(1);
        bit_in(1, 1);
        idle(2);
        cyc(0, 1, 1, 1, 0, '0, '0, 1);
        idle(2);

        // ena gaps inside a match, then rst after 3 of 4 bits.
        cyc(1, 0, 0, 1, 0, '0, '0, 0);
        bit_in(1, 1); idle(2); bit_in(0, 1); idle(1); bit_in(0, 1); idle(3); bit_in(1, 1);
        bit_in(1, 1); bit_in(0, 1); bit_in(0, 1);
        cyc(1, 1, 1, 1, 0, '0, '0, 0);
        bit_in(1, 1);
        idle(1);

        // len 0: detector disabled.
        cyc(0, 1, 0, 1, 1, 8'h00, 4'd0, 0);
        for (int i = 0; i < 64; i++) bit_in(1'($urandom), 1'($urandom));

        // Oversized length clamps to PAT_W.
        cyc(0, 1, 0, 1, 1, 8'hA5, 4'd11, 0);
        pv = 8'hA5;
        for (int i = PAT_W - 1; i >= 0; i--) bit_in(pv[i], 1);
        for (int i = PAT_W - 1; i >= 0; i--) bit_in(pv[i], 1);
        idle(1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            bit r, e, l, c;
            logic [LEN_W-1:0] pl;
            r  = ($urandom % 80) == 0;
            e  = ($urandom % 8) != 0;
            l  = ($urandom % 32) == 0;
            c  = ($urandom % 60) == 0;
            pl = (($urandom % 16) < 12) ? LEN_W'(1 + $urandom % 4) : LEN_W'($urandom % 12);
            cyc(r, e, 1'($urandom), 1'($urandom), l, PAT_W'($urandom), pl, c);
        end

        idle(2);
        repeat (2) @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
